bank_rd_sched: RTL and testbench
================================

Name: bank_rd_sched

Overview:
- Read scheduler for the 4-bank memory.
- Arbitrates read requests from 4 requesters with round-robin priority and issues at most one read per cycle to the addressed bank.
- Tracks each read through a RD_LATENCY-deep pipeline so that the 4:1 output mux select and return-valid line up exactly with the returning bank data.
- Sits between the requester ports and the bank array / output mux.

Parameters:
- DATA_WIDTH, 8, width of returned bank data. Passed through for mux sizing; not used internally.
- ADDR_WIDTH, 5, top-level address width. Bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the bank; the rest form the in-bank address.
- RD_LATENCY, 2, cycles from o_bank_en asserted to bank data valid. Legal range 1..8.

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  4  per-requester read request, level; held until granted
- i_addr  in  4*ADDR_WIDTH  requester r address at [r*ADDR_WIDTH +: ADDR_WIDTH]
- i_hold  in  1  stop issuing new reads and drain the pipeline
- o_gnt  out  4  one-hot grant, combinational in the request cycle
- o_bank_en  out  4  one-hot bank read enable, registered
- o_bank_addr  out  ADDR_WIDTH-2  in-bank address, registered, valid with o_bank_en
- o_mux_sel  out  2  output mux select, valid with o_rd_valid
- o_rd_valid  out  1  returned data on the mux output is valid this cycle
- o_rd_id  out  2  requester index owning the returned data
- o_idle  out  1  no reads in flight and the FSM is in HELD

Behaviour:
- Reset (async, active-low): all outputs 0; round-robin pointer = 0; pipeline cleared; FSM = RUN.
- FSM states: RUN, DRAIN, HELD.
  - RUN: arbitrate every cycle. If i_hold=1 -> DRAIN; no grant is made in the cycle i_hold is sampled high.
  - DRAIN: no grants. When the pipeline is empty -> HELD. If i_hold falls first -> RUN.
  - HELD: no grants; o_idle=1. When i_hold=0 -> RUN; arbitration resumes in the following cycle.
- Arbitration:
  - Search starts at pointer p: p, p+1, ... mod 4. The first requester with i_req set wins.
  - o_gnt is one-hot and only asserts in RUN with i_hold=0.
  - On a grant to r, the pointer becomes (r+1) mod 4. With no grant, the pointer is unchanged.
  - A requester deasserts i_req, or presents its next address, in the cycle after it sees o_gnt.
- Issue: at the edge ending grant cycle T:
  - o_bank_en[b]=1, with b = addr[ADDR_WIDTH-1:ADDR_WIDTH-2] of the winner.
  - o_bank_addr = addr[ADDR_WIDTH-3:0].
  - Both outputs return to 0 the next cycle unless a new grant occurs. There are no back-to-back restrictions; one read per cycle max.
- Return pipeline:
  - Shift register of depth RD_LATENCY holding {valid, bank, id}, loaded at issue.
  - o_rd_valid, o_mux_sel and o_rd_id are registered and assert exactly RD_LATENCY cycles after o_bank_en, i.e. at cycle T+1+RD_LATENCY relative to the grant.
  - When not valid: o_mux_sel and o_rd_id hold their last values; o_rd_valid=0.
- In-flight count = number of valid pipeline stages (0..RD_LATENCY). The pipeline is empty when the count is 0.
- Boundary conditions:
  - All 4 requesting continuously -> grants 0,1,2,3,0,... with no starvation.
  - A single requester is granted every cycle.
  - Reset mid-operation discards all in-flight reads; no o_rd_valid is produced for them.
  - i_hold raised while a grant would occur -> that request waits. It is not lost, and i_req stays high.

Optional Feature:
- Macro: BANK_RD_SCHED_PERF_CNT_EN.
- With the macro defined, the block adds two outputs:
  - o_gnt_cnt [15:0]: counts grants.
  - o_wait_cnt [15:0]: counts cycles where some i_req was high but no grant was given.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Without the macro, neither the ports nor the counter logic exist.

Test Plan:
- Reset then single request: i_req=4'b0100, addr=5'b10_011, RD_LATENCY=2.
  - Response: o_gnt=4'b0100 in cycle T; o_bank_en=4'b0100 and o_bank_addr=3'b011 at T+1; o_rd_valid=1, o_mux_sel=2'b10, o_rd_id=2 at T+3.
- All 4 requesting for 8 cycles from reset.
  - Response: grant order 0,1,2,3,0,1,2,3; o_rd_id returns in the same order, one per cycle, after the latency.
- i_hold raised with 2 reads in flight.
  - Response: no new o_gnt; both o_rd_valid pulses still occur; DRAIN->HELD; o_idle=1 one cycle after the last return; i_hold=0 -> grants resume.
- Async reset asserted mid-cycle with a read in flight.
  - Response: outputs go to 0 immediately; no o_rd_valid after release; the pointer restarts at requester 0.
- Sweep RD_LATENCY=1 and 8 with back-to-back reads to banks 3,0,1.
  - Response: o_mux_sel sequence 3,0,1 aligned exactly RD_LATENCY cycles after the o_bank_en pulses.
- With BANK_RD_SCHED_PERF_CNT_EN: 3 grants plus 2 hold cycles with requests pending.
  - Response: o_gnt_cnt=3, o_wait_cnt=2.

Source files
------------

// File: rtl/bank_rd_sched.sv
// Round-robin read scheduler for a 4-bank memory; a return pipeline lines up mux select and valid with bank data.
// Optional grant/wait performance counters are enabled with `define BANK_RD_SCHED_PERF_CNT_EN.
module bank_rd_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [3:0]              i_req,
  input  logic [4*ADDR_WIDTH-1:0] i_addr,
  input  logic                    i_hold,
  output logic [3:0]              o_gnt,
  output logic [3:0]              o_bank_en,
  output logic [ADDR_WIDTH-3:0]   o_bank_addr,
  output logic [1:0]              o_mux_sel,
  output logic                    o_rd_valid,
  output logic [1:0]              o_rd_id,
  output logic                    o_idle
`ifdef BANK_RD_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]             o_gnt_cnt,
  output logic [15:0]             o_wait_cnt
`endif
);

  // An out-of-range configuration never issues reads.
  localparam bit CFG_OK = (DATA_WIDTH > 0) && (ADDR_WIDTH >= 3) &&
                          (RD_LATENCY >= 1) && (RD_LATENCY <= 8);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HELD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    grant_en;
  logic                    grant_vld;
  logic                    win_vld;
  logic [1:0]              win_idx;
  logic [1:0]              cand;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [1:0]              win_bank;
  logic [ADDR_WIDTH-3:0]   win_ia;
  logic                    pipe_empty;

  logic [3:0]              bank_en_q, bank_en_d;
  logic [ADDR_WIDTH-3:0]   bank_addr_q, bank_addr_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic [1:0]              rd_id_q, rd_id_d;

  logic [RD_LATENCY-1:0]   rtn_vld_q, rtn_vld_d;
  logic [1:0]              rtn_bank_q [RD_LATENCY];
  logic [1:0]              rtn_bank_d [RD_LATENCY];
  logic [1:0]              rtn_id_q   [RD_LATENCY];
  logic [1:0]              rtn_id_d   [RD_LATENCY];

  // Round-robin search starting at the pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_vld && i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_addr  = i_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_bank  = win_addr[ADDR_WIDTH-1 -: 2];
  assign win_ia    = win_addr[ADDR_WIDTH-3:0];
  assign grant_vld = grant_en && win_vld;
  assign o_gnt     = grant_vld ? (4'b0001 << win_idx) : 4'b0000;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = win_idx + 2'd1;
    end
  end

  // Issue stage: one-cycle bank enable pulse per grant.
  always_comb begin
    bank_en_d   = 4'b0000;
    bank_addr_d = '0;
    if (grant_vld) begin
      bank_en_d   = 4'b0001 << win_bank;
      bank_addr_d = win_ia;
    end
  end

  // Return pipeline: stage 0 is loaded together with the bank enable.
  always_comb begin
    rtn_vld_d     = '0;
    rtn_bank_d    = rtn_bank_q;
    rtn_id_d      = rtn_id_q;
    rtn_vld_d[0]  = grant_vld;
    rtn_bank_d[0] = win_bank;
    rtn_id_d[0]   = win_idx;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rtn_vld_d[i]  = rtn_vld_q[i-1];
      rtn_bank_d[i] = rtn_bank_q[i-1];
      rtn_id_d[i]   = rtn_id_q[i-1];
    end
  end

  assign pipe_empty = ~|rtn_vld_q;

  // Return outputs: select and id keep their last value between returns.
  always_comb begin
    rd_valid_d = rtn_vld_q[RD_LATENCY-1];
    mux_sel_d  = mux_sel_q;
    rd_id_d    = rd_id_q;
    if (rtn_vld_q[RD_LATENCY-1]) begin
      mux_sel_d = rtn_bank_q[RD_LATENCY-1];
      rd_id_d   = rtn_id_q[RD_LATENCY-1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (i_hold) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_hold)        state_d = S_RUN;
        else if (pipe_empty) state_d = S_HELD;
      end
      S_HELD: begin
        if (!i_hold) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Grants are suppressed while reset is asserted so o_gnt drops immediately.
  always_comb begin
    grant_en = (state_q == S_RUN) && !i_hold && i_rst_n && CFG_OK;
    o_idle   = (state_q == S_HELD) && pipe_empty;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RUN;
      ptr_q       <= 2'd0;
      bank_en_q   <= 4'b0000;
      bank_addr_q <= '0;
      rtn_vld_q   <= '0;
      rd_valid_q  <= 1'b0;
      mux_sel_q   <= 2'd0;
      rd_id_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bank_en_q   <= bank_en_d;
      bank_addr_q <= bank_addr_d;
      rtn_vld_q   <= rtn_vld_d;
      rd_valid_q  <= rd_valid_d;
      mux_sel_q   <= mux_sel_d;
      rd_id_q     <= rd_id_d;
    end
  end

  // Payload travels under its valid bit, so it needs no reset.
  always_ff @(posedge i_clk) begin
    rtn_bank_q <= rtn_bank_d;
    rtn_id_q   <= rtn_id_d;
  end

  assign o_bank_en   = bank_en_q;
  assign o_bank_addr = bank_addr_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_mux_sel   = mux_sel_q;
  assign o_rd_id     = rd_id_q;

`ifdef BANK_RD_SCHED_PERF_CNT_EN
  logic [15:0] gnt_cnt_q, gnt_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    gnt_cnt_d  = gnt_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (grant_vld && (gnt_cnt_q != 16'hFFFF)) begin
      gnt_cnt_d = gnt_cnt_q + 16'd1;
    end
    if ((|i_req) && !grant_vld && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_cnt_q  <= 16'd0;
      wait_cnt_q <= 16'd0;
    end else begin
      gnt_cnt_q  <= gnt_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign o_gnt_cnt  = gnt_cnt_q;
  assign o_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_bank_rd_sched.sv
// Bench for bank_rd_sched: three instances (RD_LATENCY 2, 1, 8) share stimulus and are checked
// against a cycle-indexed reference model of grants, returns and idle.
module tb_bank_rd_sched;

  localparam int AW = 5;
  localparam int NK = 3;
  localparam int HN = 4096;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req   = 4'b0000;
  logic [4*AW-1:0] addr  = '0;
  logic            hold  = 1'b0;

  logic [3:0]      gnt_w  [NK];
  logic [3:0]      en_w   [NK];
  logic [AW-3:0]   ba_w   [NK];
  logic [1:0]      sel_w  [NK];
  logic            vld_w  [NK];
  logic [1:0]      id_w   [NK];
  logic            idle_w [NK];
`ifdef BANK_RD_SCHED_PERF_CNT_EN
  logic [15:0]     gc_w   [NK];
  logic [15:0]     wc_w   [NK];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
  endfunction

  for (genvar k = 0; k < NK; k++) begin : g_dut
    bank_rd_sched #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(AW),
      .RD_LATENCY((k == 0) ? 2 : ((k == 1) ? 1 : 8))
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_addr     (addr),
      .i_hold     (hold),
      .o_gnt      (gnt_w[k]),
      .o_bank_en  (en_w[k]),
      .o_bank_addr(ba_w[k]),
      .o_mux_sel  (sel_w[k]),
      .o_rd_valid (vld_w[k]),
      .o_rd_id    (id_w[k]),
      .o_idle     (idle_w[k])
`ifdef BANK_RD_SCHED_PERF_CNT_EN
      ,
      .o_gnt_cnt  (gc_w[k]),
      .o_wait_cnt (wc_w[k])
`endif
    );
  end

  // Reference model: per-cycle grant history since the last reset release.
  int cyc;
  int ptr;
  int last_win;
  int gid   [HN];
  int gbank [HN];
  int gia   [HN];
  bit hold_h[HN];
  int last_sel [NK];
  int last_id  [NK];
  int exp_gcnt;
  int exp_wcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    cyc = 0;
    ptr = 0;
    last_win = -1;
    exp_gcnt = 0;
    exp_wcnt = 0;
    for (int i = 0; i < HN; i++) begin
      gid[i] = -1;
      gbank[i] = 0;
      gia[i] = 0;
      hold_h[i] = 1'b0;
    end
    for (int k = 0; k < NK; k++) begin
      last_sel[k] = 0;
      last_id[k] = 0;
    end
  endtask

  function automatic bit quiet(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && gid[i] >= 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock cycle: inputs were driven by the caller just after the edge.
  task automatic step();
    int t, w, lk, g, r;
    bit run, e_vld, e_idle;
    logic [3:0] e_gnt, e_en;
    logic [2:0] e_ba;
    t = cyc;
    #1;
    // The scheduler may grant in cycle t only if hold was low in cycle t-1 and is low now.
    run = (t == 0) ? 1'b1 : !hold_h[t-1];
    w = -1;
    if (run && hold === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        r = (ptr + i) % 4;
        if (w < 0 && req[r]) w = r;
      end
    end
    hold_h[t] = hold;
    gid[t] = w;
    if (w >= 0) begin
      gbank[t] = int'(addr[w*AW+3 +: 2]);
      gia[t]   = int'(addr[w*AW +: 3]);
      ptr      = (w + 1) % 4;
    end
    last_win = w;
    e_gnt = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    e_en = 4'b0000;
    e_ba = 3'b000;
    if (t >= 1 && gid[t-1] >= 0) begin
      e_en = 4'b0001 << gbank[t-1];
      e_ba = 3'(gia[t-1]);
    end
    for (int k = 0; k < NK; k++) begin
      lk = lat(k);
      g = t - 1 - lk;
      e_vld = 1'b0;
      if (g >= 0 && gid[g] >= 0) begin
        e_vld = 1'b1;
        last_sel[k] = gbank[g];
        last_id[k]  = gid[g];
      end
      e_idle = (t >= 2) && hold_h[t-1] && hold_h[t-2] && quiet(t - 1 - lk, t - 2);
      chk($sformatf("gnt L%0d", lk),       gnt_w[k],  e_gnt);
      chk($sformatf("bank_en L%0d", lk),   en_w[k],   e_en);
      chk($sformatf("bank_addr L%0d", lk), ba_w[k],   e_ba);
      chk($sformatf("rd_valid L%0d", lk),  vld_w[k],  e_vld);
      chk($sformatf("mux_sel L%0d", lk),   sel_w[k],  last_sel[k]);
      chk($sformatf("rd_id L%0d", lk),     id_w[k],   last_id[k]);
      chk($sformatf("idle L%0d", lk),      idle_w[k], e_idle);
`ifdef BANK_RD_SCHED_PERF_CNT_EN
      chk($sformatf("gnt_cnt L%0d", lk),   gc_w[k],   exp_gcnt);
      chk($sformatf("wait_cnt L%0d", lk),  wc_w[k],   exp_wcnt);
`endif
    end
    if (w >= 0) exp_gcnt++;
    if ((|req) && w < 0) exp_wcnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit chk_zero);
    #2 rst_n = 1'b0;
    #1;
    if (chk_zero) begin
      for (int k = 0; k < NK; k++) begin
        chk("rst gnt",       gnt_w[k],  4'b0000);
        chk("rst bank_en",   en_w[k],   4'b0000);
        chk("rst bank_addr", ba_w[k],   3'b000);
        chk("rst rd_valid",  vld_w[k],  1'b0);
        chk("rst mux_sel",   sel_w[k],  2'b00);
        chk("rst rd_id",     id_w[k],   2'b00);
        chk("rst idle",      idle_w[k], 1'b0);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic set_addr(input int r, input logic [4:0] a);
    addr[r*AW +: AW] = a;
  endtask

  bit         pend [4];
  logic [4:0] pa   [4];
  bit         hmode;

  initial begin
    model_clear();
    // Reset state, with requests asserted to show grants are gated.
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      chk("init gnt",     gnt_w[k],  4'b0000);
      chk("init bank_en", en_w[k],   4'b0000);
      chk("init valid",   vld_w[k],  1'b0);
      chk("init idle",    idle_w[k], 1'b0);
    end
    req = 4'b0000;
    rst_n = 1'b1;
    model_clear();

    // Single request from requester 2 to bank 2, in-bank address 3.
    req = 4'b0100;
    set_addr(2, 5'b10_011);
    step();
    req = 4'b0000;
    chk("t1 bank_en", en_w[0], 4'b0100);
    chk("t1 bank_addr", ba_w[0], 3'b011);
    step();
    step();
    chk("t3 rd_valid", vld_w[0], 1'b1);
    chk("t3 mux_sel", sel_w[0], 2'b10);
    chk("t3 rd_id", id_w[0], 2'd2);
    repeat (10) step();

    // All four requesting continuously from reset.
    do_reset(1'b0);
    for (int r = 0; r < 4; r++) set_addr(r, 5'($urandom));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr gnt", gnt_w[0], 4'b0001 << (i % 4));
      step();
    end
    req = 4'b0000;
    repeat (10) step();

    // Hold raised with two reads in flight and a request pending.
    set_addr(0, 5'b00_101);
    set_addr(1, 5'b11_110);
    set_addr(3, 5'b01_001);
    req = 4'b0011;
    step();
    req = 4'b0010;
    step();
    req = 4'b1000;
    hold = 1'b1;
    repeat (14) begin
      #1 chk("hold gnt", gnt_w[0], 4'b0000);
      step();
    end
    chk("held idle L8", idle_w[2], 1'b1);
    hold = 1'b0;
    step();
    #1 chk("resume gnt", gnt_w[0], 4'b1000);
    step();
    req = 4'b0000;
    repeat (12) step();

    // Asynchronous reset while a read is in flight.
    set_addr(2, 5'b01_010);
    req = 4'b0100;
    step();
    do_reset(1'b1);
    req = 4'b0000;
    repeat (12) step();
    req = 4'b1010;
    set_addr(1, 5'b10_001);
    set_addr(3, 5'b00_111);
    #1 chk("ptr restart gnt", gnt_w[0], 4'b0010);
    step();
    req = 4'b1000;
    step();
    req = 4'b0000;
    repeat (12) step();

    // Back-to-back reads to banks 3, 0, 1.
    set_addr(0, 5'b11_000);
    set_addr(1, 5'b00_001);
    set_addr(2, 5'b01_010);
    req = 4'b0111;
    step();
    req = 4'b0110;
    step();
    req = 4'b0100;
    step();
    req = 4'b0000;
    repeat (12) step();

    // Three grants, then two hold cycles with a request pending.
    do_reset(1'b0);
    req = 4'b0111;
    step();
    req = 4'b0110;
    step();
    req = 4'b0100;
    step();
    req = 4'b1000;
    hold = 1'b1;
    step();
    step();
    req = 4'b0000;
`ifdef BANK_RD_SCHED_PERF_CNT_EN
    chk("perf gnt_cnt", gc_w[0], 16'd3);
    chk("perf wait_cnt", wc_w[0], 16'd2);
`endif
    hold = 1'b0;
    repeat (12) step();

    // Randomized traffic with bursts of hold.
    do_reset(1'b0);
    hmode = 1'b0;
    for (int r = 0; r < 4; r++) begin
      pend[r] = 1'b0;
      pa[r] = 5'd0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 4; r++) begin
        if (last_win == r) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pa[r] = 5'($urandom);
        end
        req[r] = pend[r];
        set_addr(r, pa[r]);
      end
      if ($urandom_range(0, 15) == 0) hmode = !hmode;
      hold = hmode;
      step();
    end
    hold = 1'b0;
    req = 4'b0000;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
